mem_access: RTL and testbench

- Memory-access pipeline stage sitting directly downstream of the execute stage.
- Consumes the execute stage's ALU result, store data, byte write enables and destination-register controls.
- Performs loads and stores over a request/grant/response data-memory bus, stalling the pipeline while a transaction is outstanding.
- Registers aligned, extended writeback data and destination controls into the writeback stage.

---
 rtl/mem_access_pkg.sv | 15 +
 rtl/load_align.sv | 29 ++
 rtl/mem_access.sv | 97 +++++++++
 tb/tb_mem_access.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared constants for the memory-access stage: load size/sign codes and FSM encodings.
package mem_access_pkg;

   localparam logic [2:0] LOAD_W  = 3'd0;
   localparam logic [2:0] LOAD_H  = 3'd1;
   localparam logic [2:0] LOAD_HU = 3'd2;
   localparam logic [2:0] LOAD_B  = 3'd3;
   localparam logic [2:0] LOAD_BU = 3'd4;

   typedef enum logic {
      MEM_IDLE = 1'b0,
      MEM_WAIT = 1'b1
   } mem_state_e;

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a load word and sign/zero extends it.
module load_align
   import mem_access_pkg::*;
(
   input  logic [1:0]  addr,
   input  logic [2:0]  load_op,
   input  logic [31:0] rdata,
   output logic [31:0] data
);

   logic [31:0] byte_sh;
   logic [31:0] half_sh;

   // Shift the lane down to bit 0; misaligned halfwords simply use addr[1].
   assign byte_sh = rdata >> {addr, 3'b000};
   assign half_sh = rdata >> {addr[1], 4'b0000};

   always_comb begin
      data = rdata;
      case (load_op)
         LOAD_H:  data = {{16{half_sh[15]}}, half_sh[15:0]};
         LOAD_HU: data = {16'h0000, half_sh[15:0]};
         LOAD_B:  data = {{24{byte_sh[7]}}, byte_sh[7:0]};
         LOAD_BU: data = {24'h000000, byte_sh[7:0]};
         default: data = rdata;
      endcase
   end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage: issues loads/stores on the request/grant/response bus,
// stalls upstream while a transaction is outstanding, and registers writeback controls.
module mem_access
   import mem_access_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_WIDTH-1:0] alu_data_mem,
   input  logic [DATA_WIDTH-1:0] reg_t_data_mem,
   input  logic [3:0]            mem_we_mem,
   input  logic                  reg_d_we_mem,
   input  logic [ADDR_WIDTH-1:0] reg_d_addr_mem,
   input  logic                  reg_d_data_sel_mem,
   input  logic [2:0]            load_op_mem,
   output logic                  dmem_req,
   output logic [DATA_WIDTH-1:0] dmem_addr,
   output logic [3:0]            dmem_we,
   output logic [DATA_WIDTH-1:0] dmem_wdata,
   input  logic                  dmem_gnt,
   input  logic                  dmem_rvalid,
   input  logic [DATA_WIDTH-1:0] dmem_rdata,
   output logic                  stall_mem,
   output logic                  reg_d_we_wb,
   output logic [ADDR_WIDTH-1:0] reg_d_addr_wb,
   output logic [DATA_WIDTH-1:0] reg_d_data_wb
);

   mem_state_e      state;
   logic            is_store;
   logic            is_load;
   logic [DATA_WIDTH-1:0] load_data;

   // A store with a stray load flag is treated as a store.
   assign is_store = |mem_we_mem;
   assign is_load  = reg_d_data_sel_mem & reg_d_we_mem & ~is_store;

   assign dmem_addr  = {alu_data_mem[DATA_WIDTH-1:2], 2'b00};
   assign dmem_we    = mem_we_mem;
   assign dmem_wdata = reg_t_data_mem << {alu_data_mem[1:0], 3'b000};

   // Gated by rst_n so nothing is requested or stalled while reset is held.
   always_comb begin
      dmem_req  = 1'b0;
      stall_mem = 1'b0;
      if (rst_n) begin
         if (state == MEM_IDLE) begin
            dmem_req  = is_store | is_load;
            stall_mem = is_store ? ~dmem_gnt : is_load;
         end else begin
            stall_mem = ~dmem_rvalid;
         end
      end
   end

   load_align u_load_align (
      .addr    (alu_data_mem[1:0]),
      .load_op (load_op_mem),
      .rdata   (dmem_rdata),
      .data    (load_data)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= MEM_IDLE;
         reg_d_we_wb   <= 1'b0;
         reg_d_addr_wb <= '0;
         reg_d_data_wb <= '0;
      end else begin
         // Bubble by default; each path below overrides when it completes.
         reg_d_we_wb <= 1'b0;
         case (state)
            MEM_IDLE: begin
               if (is_load) begin
                  if (dmem_gnt) state <= MEM_WAIT;
               end else if (!is_store || dmem_gnt) begin
                  reg_d_we_wb   <= reg_d_we_mem;
                  reg_d_addr_wb <= reg_d_addr_mem;
                  reg_d_data_wb <= alu_data_mem;
               end
            end
            MEM_WAIT: begin
               if (dmem_rvalid) begin
                  reg_d_we_wb   <= reg_d_we_mem;
                  reg_d_addr_wb <= reg_d_addr_mem;
                  reg_d_data_wb <= load_data;
                  state         <= MEM_IDLE;
               end
            end
            default: state <= MEM_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access; writebacks are checked by a scoreboard monitor.
module tb_mem_access;
   import mem_access_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] alu_data_mem, reg_t_data_mem, dmem_addr, dmem_wdata, dmem_rdata, reg_d_data_wb;
   logic [3:0]  mem_we_mem, dmem_we;
   logic        reg_d_we_mem, reg_d_data_sel_mem, dmem_req, dmem_gnt, dmem_rvalid, stall_mem, reg_d_we_wb;
   logic [4:0]  reg_d_addr_mem, reg_d_addr_wb;
   logic [2:0]  load_op_mem;

   int checks = 0;
   int errors = 0;
   logic [36:0] exp_q[$];

   always #5 clk = ~clk;

   mem_access #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_data_mem(alu_data_mem), .reg_t_data_mem(reg_t_data_mem), .mem_we_mem(mem_we_mem),
      .reg_d_we_mem(reg_d_we_mem), .reg_d_addr_mem(reg_d_addr_mem),
      .reg_d_data_sel_mem(reg_d_data_sel_mem), .load_op_mem(load_op_mem),
      .dmem_req(dmem_req), .dmem_addr(dmem_addr), .dmem_we(dmem_we), .dmem_wdata(dmem_wdata),
      .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
      .stall_mem(stall_mem), .reg_d_we_wb(reg_d_we_wb), .reg_d_addr_wb(reg_d_addr_wb),
      .reg_d_data_wb(reg_d_data_wb)
   );

   task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Monitor: every writeback pulse must match the oldest expected entry.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && reg_d_we_wb === 1'b1) begin
         if (exp_q.size() == 0) chk("unexpected_wb", {reg_d_addr_wb, reg_d_data_wb}, 37'h0);
         else chk("wb", {reg_d_addr_wb, reg_d_data_wb}, exp_q.pop_front());
      end
   end

   task automatic idle();
      alu_data_mem = 0; reg_t_data_mem = 0; mem_we_mem = 0; reg_d_we_mem = 0;
      reg_d_addr_mem = 0; reg_d_data_sel_mem = 0; load_op_mem = LOAD_W;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [31:0] addr, input logic [2:0] op, input logic [31:0] rdata,
                          input logic [4:0] rd, input logic [31:0] exp, input int nwait);
      int stalls = 0;
      alu_data_mem = addr; reg_d_we_mem = 1; reg_d_data_sel_mem = 1; reg_d_addr_mem = rd;
      load_op_mem = op; dmem_gnt = 1;
      @(negedge clk);
      chk("ld_req", dmem_req, 1); chk("ld_addr", dmem_addr, {addr[31:2], 2'b00});
      chk("ld_we", dmem_we, 0);
      stalls += stall_mem;
      step(); dmem_gnt = 0;
      for (int i = 0; i < nwait; i++) begin
         @(negedge clk);
         chk("wait_req", dmem_req, 0);
         stalls += stall_mem;
         step();
      end
      dmem_rvalid = 1; dmem_rdata = rdata;
      exp_q.push_back({rd, exp});
      @(negedge clk);
      chk("rsp_stall", stall_mem, 0);
      step(); dmem_rvalid = 0; dmem_rdata = 0; idle();
      chk("stall_cycles", stalls, nwait + 1);
   endtask

   initial begin
      rst_n = 0; dmem_gnt = 0; dmem_rvalid = 0; dmem_rdata = 0; idle();
      repeat (2) @(negedge clk);
      chk("rst_we", reg_d_we_wb, 0); chk("rst_addr", reg_d_addr_wb, 0);
      chk("rst_data", reg_d_data_wb, 0); chk("rst_req", dmem_req, 0); chk("rst_stall", stall_mem, 0);
      step(); rst_n = 1;

      // ALU pass-through
      alu_data_mem = 32'h1234; reg_d_we_mem = 1; reg_d_addr_mem = 5;
      exp_q.push_back({5'd5, 32'h1234});
      @(negedge clk);
      chk("alu_stall", stall_mem, 0); chk("alu_req", dmem_req, 0);
      step(); idle();
      @(negedge clk);
      chk("alu_stall2", stall_mem, 0);

      // Store byte, grant delayed by two cycles
      step();
      alu_data_mem = 32'h103; reg_t_data_mem = 32'hAB; mem_we_mem = 4'b1000;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("sb_req", dmem_req, 1); chk("sb_addr", dmem_addr, 32'h100);
         chk("sb_wdata", dmem_wdata, 32'hAB000000); chk("sb_we", dmem_we, 4'b1000);
         chk("sb_stall", stall_mem, 1);
         step();
      end
      dmem_gnt = 1;
      @(negedge clk);
      chk("sb_gnt_stall", stall_mem, 0); chk("sb_gnt_req", dmem_req, 1);
      step(); dmem_gnt = 0; idle();

      // Stray grant with no request changes nothing
      dmem_gnt = 1;
      @(negedge clk);
      chk("stray_gnt_stall", stall_mem, 0);
      step(); dmem_gnt = 0;

      do_load(32'h202, LOAD_B,  32'h00800000, 5'd7,  32'hFFFFFF80, 3);
      do_load(32'h2,   LOAD_HU, 32'hBEEF0000, 5'd8,  32'h0000BEEF, 1);
      do_load(32'h0,   LOAD_W,  32'hDEADBEEF, 5'd9,  32'hDEADBEEF, 0);
      do_load(32'h3,   LOAD_BU, 32'h80000000, 5'd10, 32'h00000080, 2);
      do_load(32'h2,   LOAD_H,  32'h80010000, 5'd11, 32'hFFFF8001, 1);

      // Reset while a load is outstanding: the response must be dropped
      alu_data_mem = 32'h40; reg_d_we_mem = 1; reg_d_data_sel_mem = 1; reg_d_addr_mem = 12;
      dmem_gnt = 1;
      step(); dmem_gnt = 0;
      @(negedge clk);
      chk("wait_stall", stall_mem, 1);
      #2 rst_n = 0; #1;
      chk("rst_mid_stall", stall_mem, 0); chk("rst_mid_req", dmem_req, 0);
      chk("rst_mid_we", reg_d_we_wb, 0);
      idle();
      step(); rst_n = 1;
      @(negedge clk);
      chk("post_rst_stall", stall_mem, 0); chk("post_rst_req", dmem_req, 0);
      step(); dmem_rvalid = 1; dmem_rdata = 32'hCAFEF00D;
      @(negedge clk);
      chk("late_rsp_stall", stall_mem, 0); chk("late_rsp_req", dmem_req, 0);
      step(); dmem_rvalid = 0;
      @(negedge clk);
      chk("late_rsp_we", reg_d_we_wb, 0);

      repeat (3) step();
      chk("queue_empty", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
